// File: rtl/rv_core_pkg.sv
// Shared definitions for the RV32I core front end.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : addi x0,x0,0, presented to decode when no instruction is held
//   fetch_state_e : fetch sequencer states
//   fetch_entry_t : one buffered fetch result {pc, instr}
package rv_core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   i_clear     : empties the FIFO at the next edge; wins over push and pop
//   i_push      : write i_data (ignored when full)
//   i_pop       : drop head entry (ignored when empty)
//   o_data      : head entry (undefined when empty)
//   o_empty     : no entries held
//   o_count     : number of entries held, 0..DEPTH
module fetch_fifo
  import rv_core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  output fetch_entry_t  o_data,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the fetch PC, requests words from
// instruction memory (req/gnt, in-order rvalid), buffers returned words with
// their PC and hands them to decode over a valid/ready handshake. A redirect
// flushes the buffer and restarts fetch at the new address once every stale
// response has come back.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   imem_req/imem_addr  : fetch request and word-aligned address
//   imem_gnt            : memory accepts the request this cycle
//   imem_rvalid/rdata   : in-order response
//   redirect/redirect_pc: taken branch/jump target, low two bits ignored
//   instr_valid/ready   : decode handshake on the head entry
//   Instr, PC, PCPlus4  : head entry (nop / 0 / 0 when not valid)
//
// state | meaning
// ------+-------------------------------------------------------------------
// RUN   | normal fetch; issue while buffered + in-flight < DEPTH
// DRAIN | after a redirect: no requests, discard responses until none in flight
module ifetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fpc;

  logic [CW-1:0]   w_buf_count;
  logic [CW-1:0]   w_out_count;
  logic [CW-1:0]   w_out_after;
  logic [CW:0]     w_inflight;
  logic            w_buf_empty;
  logic            w_tag_empty;
  fetch_entry_t    w_tag_in;
  fetch_entry_t    w_tag_head;
  fetch_entry_t    w_buf_in;
  fetch_entry_t    w_buf_head;

  logic            w_req;
  logic            w_grant;
  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic            w_clear;
  logic            w_unused;

  // The tag FIFO occupancy is the outstanding-request count.
  // A response with nothing outstanding is a protocol error and is dropped.
  assign w_rsp      = imem_rvalid && !w_tag_empty;
  assign w_inflight = {1'b0, w_buf_count} + {1'b0, w_out_count};
  // No grant can occur in a redirect or DRAIN cycle, so only the discard counts.
  assign w_out_after = w_out_count - CW'(w_rsp);

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_push      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      RUN: begin
        w_req = !redirect && (w_inflight < (CW + 1)'(DEPTH));
        if (redirect) begin
          w_clear = 1'b1;
          if (w_out_after != '0) w_state_nxt = DRAIN;
        end else begin
          w_push = w_rsp;
        end
      end
      DRAIN: begin
        if (w_out_after == '0) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc <= RESET_PC;
    end else if (redirect) begin
      r_fpc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (w_grant) begin
      r_fpc <= r_fpc + XLEN'(4);
    end
  end

  assign imem_req  = w_req && !reset;
  assign imem_addr = r_fpc;
  assign w_grant   = imem_req && imem_gnt;

  assign w_tag_in = '{pc: r_fpc, instr: '0};

  fetch_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clear (1'b0),
    .i_push  (w_grant),
    .i_data  (w_tag_in),
    .i_pop   (w_rsp),
    .o_data  (w_tag_head),
    .o_empty (w_tag_empty),
    .o_count (w_out_count)
  );

  assign w_buf_in = '{pc: w_tag_head.pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_buf_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_data  (w_buf_in),
    .i_pop   (w_pop),
    .o_data  (w_buf_head),
    .o_empty (w_buf_empty),
    .o_count (w_buf_count)
  );

  assign instr_valid = !w_buf_empty && !reset;
  assign w_pop       = instr_valid && instr_ready;
  assign Instr       = instr_valid ? w_buf_head.instr : NOP_INSTR;
  assign PC          = instr_valid ? w_buf_head.pc : '0;
  assign PCPlus4     = instr_valid ? (w_buf_head.pc + XLEN'(4)) : '0;

  assign w_unused = ^{w_tag_head.instr, redirect_pc[1:0]};

endmodule
